icp_mem: RTL and testbench
==========================

Name: icp_mem

Overview:
- Multi-port 64-bit word memory: the responder side of the 4-port op/addr/data interface the intcode processor core drives.
- Each cycle, serves up to NUM_PORTS independent READ/WRITE requests with a fixed 1-cycle registered read latency.
- Has a lowest-priority host port for program load and result dump while the core is idle, reset or halted.

Parameters:
- NUM_PORTS, 4, number of core-facing request ports.
- ADDR_W, 13, port address width.
- DATA_W, 64, word width.
- DEPTH, 8192, words of storage; power of two, at most 2**ADDR_W.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous active-high reset.
- i_op[NUM_PORTS-1:0]  in  2 each  per-port op: 0 NONE, 1 READ, 2 WRITE, 3 reserved.
- i_addr[NUM_PORTS-1:0]  in  ADDR_W each  per-port word address.
- i_data[NUM_PORTS-1:0]  in  DATA_W each  per-port write data.
- o_data[NUM_PORTS-1:0]  out  DATA_W each  per-port read data.
- i_host_valid  in  1  host request valid.
- i_host_we  in  1  1 = host write, 0 = host read.
- i_host_addr  in  ADDR_W  host address.
- i_host_wdata  in  DATA_W  host write data.
- o_host_ready  out  1  host request accepted this cycle.
- o_host_rvalid  out  1  host read data valid.
- o_host_rdata  out  DATA_W  host read data.
- o_err  out  1  sticky error flag; exists only with ICP_MEM_BOUNDS_CHECK_EN.

Behaviour:
- Reset, one clock, synchronous, active-high:
  - o_data all 0; o_host_rvalid 0; o_host_rdata 0; o_err 0.
  - Array contents are not cleared.
  - Requests presented in the reset cycle are ignored; no writes occur.
- READ on port p, sampled at edge k: o_data[p] = mem[addr] after edge k, usable by the requester at edge k+1.
- o_data[p] holds its last value while port p is NONE, WRITE or reserved.
- A held READ with a changing address returns the new address's data each cycle.
- WRITE on port p, sampled at edge k: mem[addr] = i_data[p] after edge k.
- Read-during-write to the same address in the same cycle returns old data (read-first), both on other ports and from the host.
- Multiple same-cycle WRITEs to one address: lowest port index wins; the other writes to that address are dropped.
- Writes to distinct addresses all commit.
- Op 3 (reserved) behaves as NONE.
- Host handshake:
  - o_host_ready is combinational: 1 iff !i_rst and every i_op is NONE or reserved.
  - Transfer occurs when i_host_valid && o_host_ready.
  - Host write commits at that edge.
  - Host read: o_host_rvalid pulses 1 for exactly one cycle after the accepting edge, with o_host_rdata = mem[addr].
  - o_host_rdata holds its value otherwise.
- Host starvation while the core is active is permitted; the host must hold valid/we/addr/wdata until ready.
- No state machine beyond the host rvalid flag. The read datapath is purely registered; there are no internal stalls.

Optional Feature:
- Macro: ICP_MEM_BOUNDS_CHECK_EN.
- Defined:
  - An address >= DEPTH on any core or host access is out of range.
  - Out-of-range reads return 0.
  - Out-of-range writes are dropped.
  - o_err sets the cycle after the first out-of-range access and stays set until reset.
- Undefined:
  - Addresses are truncated to log2(DEPTH) bits and wrap modulo DEPTH.
  - o_err port absent.

Decomposition:
- Package icp_mem_pkg:
  - Op encodings MEM_OP_NONE=0, MEM_OP_READ=1, MEM_OP_WRITE=2, MEM_OP_RSVD=3.
  - Defaults ICP_ADDR_W=13, ICP_DATA_W=64, ICP_NUM_PORTS=4.
  - Op typedef, 2-bit.
  - Shared with the processor core.
- Sub-module icp_mem_wr_arb: per-port write-enable mask after same-address lowest-index-wins resolution, plus the host_ready idle detect. Purely combinational; the array and read registers stay in icp_mem.

Test Plan:
- Host writes 1,2,3,99 to addresses 0..3 with core ports NONE; then all ports READ addresses 0..3 -> o_data = {1,2,3,99} one cycle after the sampling edge.
- Port0 WRITE addr 5 = 0xDEAD while port1 READs addr 5 the same cycle -> port1 gets the old value; a READ next cycle gets 0xDEAD.
- Ports 0 and 2 WRITE addr 7 with 0x11 and 0x22 the same cycle -> mem[7] = 0x11. Port3 WRITE addr 8 = 0x33 in the same cycle commits.
- Host read valid asserted while port1 READs -> ready 0, no rvalid. Ports go NONE -> ready 1, rvalid pulses one cycle with the correct data.
- Assert i_rst in the same cycle as port0 WRITE addr 9 = 0x55 -> mem[9] unchanged, o_data all 0, o_host_rvalid 0.
- With DEPTH=4096 and macro defined: READ addr 0x1000 -> 0, o_err 1 next cycle and sticky. Without the macro: READ returns mem[0].

Source files
------------

// File: rtl/icp_mem_pkg.sv
// icp_mem_pkg: op encodings and default widths shared by icp_mem and the
// intcode processor core that drives it.
package icp_mem_pkg;

  localparam int ICP_ADDR_W    = 13;
  localparam int ICP_DATA_W    = 64;
  localparam int ICP_NUM_PORTS = 4;

  typedef logic [1:0] mem_op_t;

  localparam mem_op_t MEM_OP_NONE  = 2'd0;
  localparam mem_op_t MEM_OP_READ  = 2'd1;
  localparam mem_op_t MEM_OP_WRITE = 2'd2;
  localparam mem_op_t MEM_OP_RSVD  = 2'd3;

  // Reserved is treated exactly like NONE everywhere.
  function automatic logic op_is_idle(mem_op_t op);
    return (op == MEM_OP_NONE) || (op == MEM_OP_RSVD);
  endfunction

endpackage

// File: rtl/icp_mem_if.sv
// icp_mem_if: core request ports plus host load/dump channel of icp_mem.
// slave = memory side, master = core/host side.
interface icp_mem_if
  import icp_mem_pkg::*;
#(
  parameter int NUM_PORTS = ICP_NUM_PORTS,
  parameter int ADDR_W    = ICP_ADDR_W,
  parameter int DATA_W    = ICP_DATA_W
);

  logic [NUM_PORTS-1:0][1:0]        i_op;
  logic [NUM_PORTS-1:0][ADDR_W-1:0] i_addr;
  logic [NUM_PORTS-1:0][DATA_W-1:0] i_data;
  logic [NUM_PORTS-1:0][DATA_W-1:0] o_data;

  logic              i_host_valid;
  logic              i_host_we;
  logic [ADDR_W-1:0] i_host_addr;
  logic [DATA_W-1:0] i_host_wdata;
  logic              o_host_ready;
  logic              o_host_rvalid;
  logic [DATA_W-1:0] o_host_rdata;

  modport slave (
    input  i_op, i_addr, i_data, i_host_valid, i_host_we, i_host_addr, i_host_wdata,
    output o_data, o_host_ready, o_host_rvalid, o_host_rdata
  );

  modport master (
    output i_op, i_addr, i_data, i_host_valid, i_host_we, i_host_addr, i_host_wdata,
    input  o_data, o_host_ready, o_host_rvalid, o_host_rdata
  );

endinterface

// File: rtl/icp_mem_wr_arb.sv
// icp_mem_wr_arb: resolves same-cycle writes that land on one word (lowest
// port index wins) and detects the core-idle condition that admits the host.
// Purely combinational.
module icp_mem_wr_arb
  import icp_mem_pkg::*;
#(
  parameter int NUM_PORTS = ICP_NUM_PORTS,
  parameter int IDX_W     = 13
) (
  input  logic                           i_rst,
  input  logic [NUM_PORTS-1:0][1:0]       i_op,
  input  logic [NUM_PORTS-1:0]            i_wreq,
  input  logic [NUM_PORTS-1:0][IDX_W-1:0] i_widx,
  output logic [NUM_PORTS-1:0]            o_we,
  output logic                            o_host_ready
);

  // A write survives only if no lower-indexed port writes the same word.
  always_comb begin
    o_we = i_wreq;
    for (int p = 1; p < NUM_PORTS; p++) begin
      for (int q = 0; q < NUM_PORTS; q++) begin
        if (q < p && i_wreq[q] && i_widx[q] == i_widx[p]) o_we[p] = 1'b0;
      end
    end
  end

  // Host gets the array only when out of reset and every core port is idle.
  always_comb begin
    o_host_ready = !i_rst;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (!op_is_idle(i_op[p])) o_host_ready = 1'b0;
    end
  end

endmodule

// File: rtl/icp_mem.sv
// icp_mem: multi-port 64-bit word memory behind the intcode core.
// One registered read per port per cycle (read-first), lowest-index-wins on
// colliding writes, and a low-priority host port used while the core is idle.
// Optional macro ICP_MEM_BOUNDS_CHECK_EN: addresses >= DEPTH read 0, drop
// writes and raise sticky o_err; otherwise addresses wrap modulo DEPTH.
module icp_mem
  import icp_mem_pkg::*;
#(
  parameter int NUM_PORTS = ICP_NUM_PORTS,
  parameter int ADDR_W    = ICP_ADDR_W,
  parameter int DATA_W    = ICP_DATA_W,
  parameter int DEPTH     = 8192
) (
  input  logic      i_clk,
  input  logic      i_rst,
  icp_mem_if.slave  bus
`ifdef ICP_MEM_BOUNDS_CHECK_EN
  ,
  output logic      o_err
`endif
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [NUM_PORTS-1:0][IDX_W-1:0] idx;
  logic [NUM_PORTS-1:0]            ok;
  logic [NUM_PORTS-1:0]            wreq;
  logic [NUM_PORTS-1:0]            we;

  logic [IDX_W-1:0] host_idx;
  logic             host_ok;
  logic             host_ready;
  logic             host_xfer;
  logic             host_wr;
  logic             host_rd;

  logic [NUM_PORTS-1:0][DATA_W-1:0] rdata_d, rdata_q;
  logic                             host_rvalid_d, host_rvalid_q;
  logic [DATA_W-1:0]                host_rdata_d, host_rdata_q;

  // Per-port address decode: word index (truncated) and range qualifier.
  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    assign idx[p]  = IDX_W'(bus.i_addr[p]);
`ifdef ICP_MEM_BOUNDS_CHECK_EN
    assign ok[p]   = ({1'b0, bus.i_addr[p]} < (ADDR_W+1)'(DEPTH));
`else
    assign ok[p]   = 1'b1;
`endif
    assign wreq[p] = (bus.i_op[p] == MEM_OP_WRITE) && ok[p];
  end

  assign host_idx = IDX_W'(bus.i_host_addr);
`ifdef ICP_MEM_BOUNDS_CHECK_EN
  assign host_ok  = ({1'b0, bus.i_host_addr} < (ADDR_W+1)'(DEPTH));
`else
  assign host_ok  = 1'b1;
`endif

  // Out-of-range writes never enter arbitration, so they cannot shadow an
  // in-range write that aliases to the same truncated index.
  icp_mem_wr_arb #(
    .NUM_PORTS (NUM_PORTS),
    .IDX_W     (IDX_W)
  ) u_wr_arb (
    .i_rst        (i_rst),
    .i_op         (bus.i_op),
    .i_wreq       (wreq),
    .i_widx       (idx),
    .o_we         (we),
    .o_host_ready (host_ready)
  );

  assign host_xfer = bus.i_host_valid && host_ready;
  assign host_wr   = host_xfer && bus.i_host_we && host_ok;
  assign host_rd   = host_xfer && !bus.i_host_we;

  // Next read data: sample the pre-edge array contents (read-first); hold otherwise.
  always_comb begin
    rdata_d = rdata_q;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (bus.i_op[p] == MEM_OP_READ) rdata_d[p] = ok[p] ? mem[idx[p]] : '0;
    end
    host_rvalid_d = host_rd;
    host_rdata_d  = host_rdata_q;
    if (host_rd) host_rdata_d = host_ok ? mem[host_idx] : '0;
  end

  // Read registers; reset clears them and discards that cycle's requests.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rdata_q       <= '0;
      host_rvalid_q <= 1'b0;
      host_rdata_q  <= '0;
    end else begin
      rdata_q       <= rdata_d;
      host_rvalid_q <= host_rvalid_d;
      host_rdata_q  <= host_rdata_d;
    end
  end

  // Array writes; contents survive reset. Host writes only when core is idle.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (we[p]) mem[idx[p]] <= bus.i_data[p];
      end
      if (host_wr) mem[host_idx] <= bus.i_host_wdata;
    end
  end

  assign bus.o_data        = rdata_q;
  assign bus.o_host_ready  = host_ready;
  assign bus.o_host_rvalid = host_rvalid_q;
  assign bus.o_host_rdata  = host_rdata_q;

`ifdef ICP_MEM_BOUNDS_CHECK_EN
  logic oor;
  logic err_d, err_q;

  // Any core READ/WRITE or accepted host access outside DEPTH latches the error.
  always_comb begin
    oor = host_xfer && !host_ok;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if ((bus.i_op[p] == MEM_OP_READ || bus.i_op[p] == MEM_OP_WRITE) && !ok[p]) oor = 1'b1;
    end
    err_d = err_q | oor;
  end

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) err_q <= 1'b0;
    else       err_q <= err_d;
  end

  assign o_err = err_q;
`endif

endmodule

// File: tb/tb_icp_mem.sv
// tb_icp_mem: directed table + hand sequences + randomized traffic for icp_mem,
// checked against a word-array reference model of the memory.
module tb_icp_mem;
  import icp_mem_pkg::*;

  localparam int NP    = 4;
  localparam int AW    = 13;
  localparam int DW    = 64;
  localparam int DEPTH = 4096;
  localparam int NV    = 10;

  logic i_clk = 1'b0;
  logic i_rst;
  always #5 i_clk = ~i_clk;

  icp_mem_if #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW)) bus ();
`ifdef ICP_MEM_BOUNDS_CHECK_EN
  logic o_err;
`endif

  icp_mem #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH)) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus)
`ifdef ICP_MEM_BOUNDS_CHECK_EN
    ,
    .o_err (o_err)
`endif
  );

  int checks   = 0;
  int failures = 0;

  // Reference model state.
  logic [DW-1:0]          model [DEPTH];
  logic [NP-1:0][DW-1:0]  exp_data;
  logic                   exp_rvalid;
  logic [DW-1:0]          exp_rdata;
  logic                   exp_err;

  typedef struct {
    logic [NP-1:0][1:0]    op;
    logic [NP-1:0][AW-1:0] addr;
    logic [NP-1:0][DW-1:0] data;
    logic [NP-1:0][DW-1:0] exp;
  } vec_t;
  vec_t tbl [NV];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  function automatic bit in_rng(input int a);
`ifdef ICP_MEM_BOUNDS_CHECK_EN
    return a < DEPTH;
`else
    return a >= 0;
`endif
  endfunction

  function automatic bit taken(input int q[$], input int v);
    foreach (q[i]) if (q[i] == v) return 1'b1;
    return 1'b0;
  endfunction

  // One clock: predict from the spec rules, step, apply writes, compare.
  task automatic cycle();
    logic [NP-1:0][DW-1:0] nd;
    logic                  nrv, nerr, rdy;
    logic [DW-1:0]         nrd;
    int                    wa[$];
    logic [DW-1:0]         wd[$];
    int                    a;
    #1;
    rdy = !i_rst;
    for (int p = 0; p < NP; p++)
      if (bus.i_op[p] == MEM_OP_READ || bus.i_op[p] == MEM_OP_WRITE) rdy = 1'b0;
    chk("host_ready", bus.o_host_ready, rdy);
    nd = exp_data; nrv = 1'b0; nrd = exp_rdata; nerr = exp_err;
    if (i_rst) begin
      nd = '0; nrd = '0; nerr = 1'b0;
    end else begin
      for (int p = 0; p < NP; p++) begin
        a = int'(bus.i_addr[p]);
        if (bus.i_op[p] == MEM_OP_READ) begin
          if (in_rng(a)) nd[p] = model[a % DEPTH];
          else begin nd[p] = '0; nerr = 1'b1; end
        end else if (bus.i_op[p] == MEM_OP_WRITE) begin
          if (!in_rng(a)) nerr = 1'b1;
          else if (!taken(wa, a % DEPTH)) begin
            wa.push_back(a % DEPTH);
            wd.push_back(bus.i_data[p]);
          end
        end
      end
      if (bus.i_host_valid && rdy) begin
        a = int'(bus.i_host_addr);
        if (!in_rng(a)) nerr = 1'b1;
        if (bus.i_host_we) begin
          if (in_rng(a)) begin wa.push_back(a % DEPTH); wd.push_back(bus.i_host_wdata); end
        end else begin
          nrv = 1'b1;
          nrd = in_rng(a) ? model[a % DEPTH] : '0;
        end
      end
    end
    @(posedge i_clk); #1;
    foreach (wa[i]) model[wa[i]] = wd[i];
    exp_data = nd; exp_rvalid = nrv; exp_rdata = nrd; exp_err = nerr;
    for (int p = 0; p < NP; p++) chk($sformatf("o_data[%0d]", p), bus.o_data[p], exp_data[p]);
    chk("host_rvalid", bus.o_host_rvalid, exp_rvalid);
    chk("host_rdata", bus.o_host_rdata, exp_rdata);
`ifdef ICP_MEM_BOUNDS_CHECK_EN
    chk("err", o_err, exp_err);
`endif
  endtask

  task automatic ports_idle();
    bus.i_op = '0; bus.i_addr = '0; bus.i_data = '0;
  endtask

  task automatic host_write(input int a, input logic [DW-1:0] d);
    ports_idle();
    bus.i_host_valid = 1'b1; bus.i_host_we = 1'b1;
    bus.i_host_addr = AW'(a); bus.i_host_wdata = d;
    cycle();
    bus.i_host_valid = 1'b0;
  endtask

  function automatic logic [AW-1:0] rnd_addr();
    if ($urandom_range(0, 7) == 0) return AW'($urandom_range(0, (1 << AW) - 1));
    return AW'($urandom_range(0, 15));
  endfunction

  initial begin
    logic [DW-1:0] save9;
    exp_data = '0; exp_rvalid = 1'b0; exp_rdata = '0; exp_err = 1'b0;
    ports_idle();
    bus.i_host_valid = 1'b0; bus.i_host_we = 1'b0; bus.i_host_addr = '0; bus.i_host_wdata = '0;

    // Reset state.
    i_rst = 1'b1;
    cycle();
    chk("rst_o_data0", bus.o_data[0], 64'd0);
    chk("rst_rvalid", bus.o_host_rvalid, 64'd0);
    i_rst = 1'b0;

    // Fill the whole array, then a known pattern at 0..9.
    for (int a = 0; a < DEPTH; a++) host_write(a, {$urandom, $urandom});
    for (int a = 0; a < 10; a++)
      host_write(a, (a < 3) ? 64'(a + 1) : (a == 3) ? 64'd99 : 64'(a * 256));

    // Directed vectors; entries are p3..p0.
    for (int i = 0; i < NV; i++) begin
      tbl[i].op = '0; tbl[i].addr = '0; tbl[i].data = '0; tbl[i].exp = '0;
    end
    tbl[0].op = {MEM_OP_READ, MEM_OP_READ, MEM_OP_READ, MEM_OP_READ};
    tbl[0].addr = {13'd3, 13'd2, 13'd1, 13'd0};
    tbl[0].exp  = {64'd99, 64'd3, 64'd2, 64'd1};
    tbl[1].op = {MEM_OP_RSVD, MEM_OP_NONE, MEM_OP_READ, MEM_OP_WRITE};
    tbl[1].addr = {13'd9, 13'd0, 13'd5, 13'd5};
    tbl[1].data = {64'hBAD, 64'd0, 64'd0, 64'hDEAD};
    tbl[1].exp  = {64'd99, 64'd3, 64'h500, 64'd1};
    tbl[2].op = {MEM_OP_NONE, MEM_OP_NONE, MEM_OP_NONE, MEM_OP_READ};
    tbl[2].addr = {13'd0, 13'd0, 13'd0, 13'd5};
    tbl[2].exp  = {64'd99, 64'd3, 64'h500, 64'hDEAD};
    tbl[3].op = {MEM_OP_WRITE, MEM_OP_WRITE, MEM_OP_NONE, MEM_OP_WRITE};
    tbl[3].addr = {13'd8, 13'd7, 13'd0, 13'd7};
    tbl[3].data = {64'h33, 64'h22, 64'd0, 64'h11};
    tbl[3].exp  = {64'd99, 64'd3, 64'h500, 64'hDEAD};
    tbl[4].op = {MEM_OP_READ, MEM_OP_READ, MEM_OP_READ, MEM_OP_READ};
    tbl[4].addr = {13'd5, 13'd7, 13'd8, 13'd7};
    tbl[4].exp  = {64'hDEAD, 64'h11, 64'h33, 64'h11};
    tbl[5].op = {MEM_OP_NONE, MEM_OP_NONE, MEM_OP_NONE, MEM_OP_READ};
    tbl[5].addr = {13'd0, 13'd0, 13'd0, 13'd0};
    tbl[5].exp  = {64'hDEAD, 64'h11, 64'h33, 64'd1};
    tbl[6].op = tbl[5].op;
    tbl[6].addr = {13'd0, 13'd0, 13'd0, 13'd1};
    tbl[6].exp  = {64'hDEAD, 64'h11, 64'h33, 64'd2};
    tbl[7].op = {MEM_OP_NONE, MEM_OP_READ, MEM_OP_NONE, MEM_OP_READ};
    tbl[7].addr = {13'd0, 13'd9, 13'd0, 13'd2};
    tbl[7].exp  = {64'hDEAD, 64'h900, 64'h33, 64'd3};
    tbl[8].op = {MEM_OP_WRITE, MEM_OP_NONE, MEM_OP_READ, MEM_OP_NONE};
    tbl[8].addr = {13'd4, 13'd0, 13'd4, 13'd0};
    tbl[8].data = {64'h44, 64'd0, 64'd0, 64'd0};
    tbl[8].exp  = {64'hDEAD, 64'h900, 64'h400, 64'd3};
    tbl[9].op = {MEM_OP_NONE, MEM_OP_NONE, MEM_OP_READ, MEM_OP_NONE};
    tbl[9].addr = {13'd0, 13'd0, 13'd4, 13'd0};
    tbl[9].exp  = {64'hDEAD, 64'h900, 64'h44, 64'd3};

    for (int i = 0; i < NV; i++) begin
      bus.i_op = tbl[i].op; bus.i_addr = tbl[i].addr; bus.i_data = tbl[i].data;
      cycle();
      for (int p = 0; p < NP; p++)
        chk($sformatf("tbl%0d_p%0d", i, p), bus.o_data[p], tbl[i].exp[p]);
    end

    // Host read blocked by a core READ, then accepted once ports go idle.
    ports_idle();
    bus.i_op[1] = MEM_OP_READ; bus.i_addr[1] = 13'd2;
    bus.i_host_valid = 1'b1; bus.i_host_we = 1'b0; bus.i_host_addr = 13'd3;
    #1 chk("hs_blocked_ready", bus.o_host_ready, 64'd0);
    cycle();
    chk("hs_blocked_rvalid", bus.o_host_rvalid, 64'd0);
    ports_idle();
    #1 chk("hs_idle_ready", bus.o_host_ready, 64'd1);
    cycle();
    chk("hs_rvalid", bus.o_host_rvalid, 64'd1);
    chk("hs_rdata", bus.o_host_rdata, 64'd99);
    bus.i_host_valid = 1'b0;
    cycle();
    chk("hs_rvalid_drop", bus.o_host_rvalid, 64'd0);
    chk("hs_rdata_hold", bus.o_host_rdata, 64'd99);

    // Address just past DEPTH: zero + sticky error, or wrap to word 0.
    bus.i_op[0] = MEM_OP_READ; bus.i_addr[0] = 13'h1000;
    cycle();
`ifdef ICP_MEM_BOUNDS_CHECK_EN
    chk("oor_rdata", bus.o_data[0], 64'd0);
    chk("oor_err", o_err, 64'd1);
    ports_idle();
    cycle(); cycle();
    chk("oor_err_sticky", o_err, 64'd1);
`else
    chk("wrap_rdata", bus.o_data[0], 64'd1);
    ports_idle();
`endif

    // Randomized traffic with heavy address collisions.
    for (int n = 0; n < 400; n++) begin
      for (int p = 0; p < NP; p++) begin
        bus.i_op[p]   = ($urandom_range(0, 2) == 0) ? MEM_OP_NONE : mem_op_t'($urandom_range(0, 3));
        bus.i_addr[p] = rnd_addr();
        bus.i_data[p] = {$urandom, $urandom};
      end
      if ($urandom_range(0, 2) == 0) bus.i_op = '0;
      bus.i_host_valid = 1'($urandom_range(0, 1));
      bus.i_host_we    = 1'($urandom_range(0, 1));
      bus.i_host_addr  = rnd_addr();
      bus.i_host_wdata = {$urandom, $urandom};
      cycle();
    end

    // Reset with a write and host request pending: both ignored.
    save9 = model[9];
    ports_idle();
    bus.i_op[0] = MEM_OP_WRITE; bus.i_addr[0] = 13'd9; bus.i_data[0] = 64'h55;
    bus.i_host_valid = 1'b1; bus.i_host_we = 1'b1; bus.i_host_addr = 13'd9; bus.i_host_wdata = 64'h77;
    i_rst = 1'b1;
    cycle();
    for (int p = 0; p < NP; p++) chk($sformatf("rst2_o_data%0d", p), bus.o_data[p], 64'd0);
    chk("rst2_rvalid", bus.o_host_rvalid, 64'd0);
    chk("rst2_rdata", bus.o_host_rdata, 64'd0);
`ifdef ICP_MEM_BOUNDS_CHECK_EN
    chk("rst2_err", o_err, 64'd0);
`endif
    i_rst = 1'b0;
    bus.i_host_valid = 1'b0;
    bus.i_op[0] = MEM_OP_READ;
    cycle();
    chk("rst2_mem9_kept", bus.o_data[0], save9);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
